// File: rtl/pix_frame_scanner.sv
// pix_frame_scanner: double-buffered frame store that scans a frame out one
// row per cycle under a valid/ready handshake, counting completed frames.
module pix_frame_scanner #(
    parameter int unsigned WIDTH  = 120,
    parameter int unsigned HEIGHT = 52
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          frame_valid,
    input  logic [WIDTH*HEIGHT-1:0]                       frame_data,
    output logic                                          frame_ready,
    output logic                                          row_valid,
    output logic [WIDTH-1:0]                              row_data,
    output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] row_idx,
    output logic                                          row_last,
    input  logic                                          row_ready,
    input  logic                                          flush,
    output logic [15:0]                                   frame_count
);

    localparam int unsigned IDX_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned FRAME_W = WIDTH * HEIGHT;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   active_q, active_d;
    logic [FRAME_W-1:0]   pend_q, pend_d;
    logic                 pend_full_q, pend_full_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 frame_ready_d;
    logic                 row_valid_d;
    logic [WIDTH-1:0]     row_data_d;
    logic                 row_last_d;

    logic                 accept;
    logic                 row_hs;
    logic                 on_last;

    assign accept  = frame_valid & frame_ready;
    assign row_hs  = row_valid & row_ready;
    assign on_last = (idx_q == IDX_W'(HEIGHT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave SCAN only when the last row drains with nothing to follow
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = SCAN;
                SCAN: if (row_hs && on_last && !pend_full_q && !accept) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Slot, row index and frame counter updates
    always_comb begin
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        if (flush) begin
            pend_full_d = 1'b0;
            idx_d       = '0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                active_d = frame_data;
                idx_d    = '0;
            end
        end else begin
            if (row_hs && on_last) begin
                cnt_d = cnt_q + CNT_W'(1);
                idx_d = '0;
                if (pend_full_q) begin
                    // frame_ready was low, so no accept can coincide here
                    active_d    = pend_q;
                    pend_full_d = 1'b0;
                end else if (accept) begin
                    active_d = frame_data;
                end
            end else begin
                if (row_hs) begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (accept) begin
                    pend_d      = frame_data;
                    pend_full_d = 1'b1;
                end
            end
        end
    end

    // Output values for the next cycle, derived from next-cycle state
    always_comb begin
        frame_ready_d = ~pend_full_d;
        row_valid_d   = (state_d == SCAN);
        row_last_d    = (state_d == SCAN) && (idx_d == IDX_W'(HEIGHT - 1));
        row_data_d    = '0;
        if (state_d == SCAN) begin
            for (int r = 0; r < int'(HEIGHT); r++) begin
                if (idx_d == IDX_W'(r)) begin
                    row_data_d = active_d[r*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            frame_ready <= 1'b0;
            row_valid   <= 1'b0;
            row_data    <= '0;
            row_last    <= 1'b0;
        end else begin
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            frame_ready <= frame_ready_d;
            row_valid   <= row_valid_d;
            row_data    <= row_data_d;
            row_last    <= row_last_d;
        end
    end

    assign row_idx     = idx_q;
    assign frame_count = cnt_q;

endmodule

// File: doc/pix_frame_scanner.md
PIX_FRAME_SCANNER -- requirements
Module: pix_frame_scanner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 120, pixels per row.
REQ-002 The block SHALL have parameter HEIGHT, default 52, rows per frame.
REQ-003 clk  input  1  single clock for all state, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 frame_valid  input  1  a complete pix frame is offered.
REQ-006 frame_data  input  WIDTH*HEIGHT  pix frame; row r occupies bits [r*WIDTH +: WIDTH].
REQ-007 frame_ready  output  1  block can accept a frame this cycle.
REQ-008 row_valid  output  1  row_data, row_idx and row_last are valid.
REQ-009 row_data  output  WIDTH  pixel row being scanned out; bit 0 is the leftmost pixel.
REQ-010 row_idx  output  clog2(HEIGHT)  index of the current row.
REQ-011 row_last  output  1  current row is HEIGHT-1.
REQ-012 row_ready  input  1  display sink accepts the row.
REQ-013 flush  input  1  synchronous discard of all held frames.
REQ-014 frame_count  output  16  completed frames, wraps 0xFFFF->0x0000.

Function
REQ-015 Storage SHALL be two frame slots: an active slot being scanned and a pending slot.
REQ-016 frame_ready SHALL be 1 exactly when the pending slot is empty; it SHALL be registered and SHALL NOT depend combinationally on frame_valid.
REQ-017 A frame accept SHALL occur when frame_valid & frame_ready are both high at a rising edge, and frame_data SHALL be captured at that edge.
REQ-018 FSM states SHALL be IDLE (no active frame) and SCAN (active frame being output).
REQ-019 In IDLE, an accepted frame SHALL go directly to the active slot, with row_idx=0, state SCAN and row_valid=1 from the next cycle.
REQ-020 In SCAN, an accepted frame SHALL go to the pending slot, and frame_ready SHALL drop the next cycle.
REQ-021 In SCAN, row_valid SHALL be 1 and row_data SHALL equal active[row_idx*WIDTH +: WIDTH].
REQ-022 Outputs SHALL hold stable while row_valid=1 and row_ready=0.
REQ-023 A row handshake (row_valid & row_ready) on a row other than the last SHALL increment row_idx by 1 on the next cycle.
REQ-024 A handshake on the last row SHALL increment frame_count by 1, then:
  - if the pending slot is full: move pending to active, row_idx=0, stay in SCAN (no bubble), and assert frame_ready the next cycle;
  - otherwise: go to IDLE with row_valid=0 the next cycle.
REQ-025 If a last-row handshake and a frame accept coincide with the pending slot empty, the accepted frame SHALL become active directly, with no bubble.
REQ-026 Throughput SHALL be one row per cycle when row_ready is held high.
REQ-027 flush SHALL have priority over all handshakes in its cycle: both slots empty, state IDLE, row_idx=0, row_valid=0, frame_ready=1 the next cycle.
REQ-028 flush SHALL leave frame_count unchanged and SHALL drop any frame offered in the same cycle.
REQ-029 A frame discarded by flush SHALL NOT be counted.
REQ-030 row_last SHALL equal (row_idx==HEIGHT-1) & row_valid.
REQ-031 HEIGHT=1 SHALL be supported: every row is the last row.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately force: state IDLE, both slots empty, row_valid=0, row_data=0, row_idx=0, row_last=0, frame_ready=0, frame_count=0.
REQ-033 frame_ready SHALL rise on the first rising edge after reset release.
REQ-034 Reset asserted mid-frame SHALL discard all frames, with no partial count.

Verification (WIDTH=4, HEIGHT=2)
REQ-035 Basic scan: frame_data=8'hA5, row_ready=1 -> row 0 = 4'h5 then row 1 = 4'hA with row_last=1 on consecutive cycles; frame_count=1; row_valid=0 afterwards.
REQ-036 Back-pressure: row_ready=0 for 3 cycles on row 0 -> row_data=4'h5 and row_idx=0 held stable; scan resumes on release.
REQ-037 Back-to-back frames: frames 8'h12 then 8'h34, second offered during the first scan, row_ready=1 -> row sequence 2,1,4,3 with no gap; frame_ready low from acceptance of 8'h34 until its promotion; frame_count=2.
REQ-038 Pending full: a third frame offered while both slots are held -> frame_ready=0 and the frame is not taken until the last-row handshake of the first frame.
REQ-039 Flush: flush on row 1 with a pending frame and a frame offered -> next cycle row_valid=0, frame_ready=1; frame_count unchanged.
REQ-040 Reset/wrap: preload frame_count to 0xFFFF via 65535 single-row frames (HEIGHT=1) -> next frame gives 0x0000; rst_n low mid-scan -> all outputs 0 immediately.
